// File: rtl/cpu_branch_resolver_pkg.sv
// Common CPU constants shared by the branch resolver and the branch predictor.
package cpu_branch_resolver_pkg;

  localparam int unsigned CPU_XLEN   = 32;
  localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/cpu_branch_fifo.sv
// In-flight branch queue: synchronous FIFO with flush; storage is not reset.
module cpu_branch_fifo
  import cpu_branch_resolver_pkg::*;
#(
  parameter int unsigned WIDTH       = 65,
  parameter int unsigned DEPTH_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_WIDTH;
  localparam int unsigned CW    = DEPTH_WIDTH + 1;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Flush empties the queue by snapping the read pointer onto the write pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_branch_resolver.sv
// Branch resolver: matches execute outcomes against queued predictions, trains the
// predictor, redirects fetch on mispredict and keeps statistics.
module cpu_branch_resolver
  import cpu_branch_resolver_pkg::*;
#(
  parameter int unsigned XLEN        = CPU_XLEN,
  parameter int unsigned DEPTH_WIDTH = 3,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  input  logic [XLEN-1:0]      pred_pc,
  input  logic                 pred_taken,
  input  logic [XLEN-1:0]      pred_target,
  output logic                 pred_ready,
  input  logic                 res_valid,
  input  logic                 res_taken,
  input  logic [XLEN-1:0]      res_target,
  output logic                 res_ready,
  output logic                 update,
  output logic [XLEN-1:0]      update_addr,
  output logic                 update_taken,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt,
  output logic                 proto_err
);

  localparam int unsigned ENTRY_W = 2 * XLEN + 1;

  logic [ENTRY_W-1:0]   wentry, rentry;
  logic [XLEN-1:0]      e_pc, e_target;
  logic                 e_taken;
  logic                 full, empty;
  logic                 deq_c, misp_c, enq_c;

  logic                 update_q, update_d;
  logic [XLEN-1:0]      update_addr_q, update_addr_d;
  logic                 update_taken_q, update_taken_d;
  logic                 redirect_q, redirect_d;
  logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;
  logic                 proto_err_q, proto_err_d;

  assign wentry                    = {pred_pc, pred_taken, pred_target};
  assign {e_pc, e_taken, e_target} = rentry;

  assign pred_ready = !full;
  assign res_ready  = !empty;
  assign deq_c      = res_valid && !empty;
  assign misp_c     = deq_c && ((res_taken != e_taken) ||
                                (res_taken && e_taken && (res_target != e_target)));
  assign enq_c      = pred_valid && !full && !misp_c;

  cpu_branch_fifo #(
    .WIDTH       (ENTRY_W),
    .DEPTH_WIDTH (DEPTH_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq_c),
    .pop   (deq_c),
    .flush (misp_c),
    .wdata (wentry),
    .rdata (rentry),
    .full  (full),
    .empty (empty)
  );

  // Strobes pulse for one cycle; their payloads hold until the next strobe.
  always_comb begin
    update_d         = deq_c;
    update_addr_d    = update_addr_q;
    update_taken_d   = update_taken_q;
    redirect_d       = misp_c;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    proto_err_d      = proto_err_q || (res_valid && empty);
    if (deq_c) begin
      update_addr_d  = e_pc;
      update_taken_d = res_taken;
      branch_cnt_d   = branch_cnt_q + CNT_WIDTH'(1);
    end
    if (misp_c) begin
      redirect_pc_d    = res_taken ? res_target : e_pc + XLEN'(INSN_BYTES);
      mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      update_q         <= 1'b0;
      update_addr_q    <= '0;
      update_taken_q   <= 1'b0;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      proto_err_q      <= 1'b0;
    end else begin
      update_q         <= update_d;
      update_addr_q    <= update_addr_d;
      update_taken_q   <= update_taken_d;
      redirect_q       <= redirect_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      proto_err_q      <= proto_err_d;
    end
  end

  assign update         = update_q;
  assign update_addr    = update_addr_q;
  assign update_taken   = update_taken_q;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
  assign proto_err      = proto_err_q;

endmodule
